fp_addsub_unit: RTL and testbench

//  Parametrised multi-cycle floating-point add/subtract unit with valid/ready handshakes on input and output.

---
 rtl/fp_addsub_pkg.sv | 34 +++
 rtl/fp_align_shifter.sv | 28 ++
 rtl/fp_addsub_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_fp_addsub_unit.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/fp_addsub_pkg.sv
// Shared definitions for the multi-cycle floating-point add/subtract unit:
// FSM encoding, derived field widths and the canonical quiet NaN pattern.
package fp_addsub_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_e;

  function automatic int word_w(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  // {hidden, man, G, R, S}
  function automatic int ext_w(input int man_w);
    return man_w + 4;
  endfunction

  // {carry, hidden, man, G, R, S}
  function automatic int sum_w(input int man_w);
    return man_w + 5;
  endfunction

  // Positive quiet NaN: exponent all ones, mantissa MSB set, rest zero.
  function automatic logic [127:0] canon_nan(input int exp_w, input int man_w);
    return ((128'(1) << (exp_w + 1)) - 128'(1)) << (man_w - 1);
  endfunction

endpackage

// File: rtl/fp_align_shifter.sv
// Combinational right barrel shifter that ORs every bit shifted out of the
// word into bit 0 (the sticky position).
module fp_align_shifter #(
  parameter int W_IN = 27,
  parameter int SH_W = 8
) (
  input  logic [W_IN-1:0] mant_i,
  input  logic [SH_W-1:0] shamt_i,
  output logic [W_IN-1:0] mant_o
);

  logic [W_IN-1:0] shifted;
  logic [W_IN-1:0] lost_mask;

  always_comb begin
    shifted   = '0;
    lost_mask = '0;
    mant_o    = '0;
    if (32'(shamt_i) >= 32'(W_IN)) begin
      mant_o = {{(W_IN-1){1'b0}}, |mant_i};
    end else begin
      shifted   = mant_i >> shamt_i;
      lost_mask = ~({W_IN{1'b1}} << shamt_i);
      mant_o    = {shifted[W_IN-1:1], shifted[0] | (|(mant_i & lost_mask))};
    end
  end

endmodule

// File: rtl/fp_addsub_unit.sv
// Multi-cycle FP add/subtract with valid/ready handshakes and status flags.
// Define FPADD_ROUND_NEAREST_EN for round-to-nearest-even; otherwise truncate.
module fp_addsub_unit
  import fp_addsub_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   res,
  output logic                   ovf,
  output logic                   unf,
  output logic                   inv
);

  localparam int W  = word_w(EXP_W, MAN_W);
  localparam int XW = ext_w(MAN_W);
  localparam int SW = sum_w(MAN_W);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0]     QNAN     = W'(canon_nan(EXP_W, MAN_W));

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic             op_q, op_d;
  logic             sx_q, sx_d;
  logic             eff_sub_q, eff_sub_d;
  logic [EXP_W-1:0] ex_q, ex_d, ey_q, ey_d;
  logic [XW-1:0]    mx_q, mx_d, my_q, my_d;
  logic [SW-1:0]    sum_q, sum_d;
  logic [EXP_W:0]   exp_q, exp_d;
  logic [W-1:0]     res_q, res_d;
  logic             ovf_q, ovf_d, unf_q, unf_d, inv_q, inv_d;

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic             sb_eff, swap;
  logic [SW-1:0]    sum_add;
  logic [MAN_W+1:0] rnd;
  logic [EXP_W:0]   exp_rnd;
  logic [EXP_W-1:0] align_d;
  logic [XW-1:0]    my_shift;

  // Returns {carry, hidden, man}; a carry means the mantissa rolled over to 2.0.
  function automatic logic [MAN_W+1:0] round_man(input logic [MAN_W+3:0] s);
`ifdef FPADD_ROUND_NEAREST_EN
    logic up;
    up = s[2] & (s[1] | s[0] | s[3]);
    return {1'b0, s[MAN_W+3:3]} + (MAN_W+2)'(up);
`else
    logic unused_grs;
    unused_grs = ^s[2:0];
    return {1'b0, s[MAN_W+3:3]};
`endif
  endfunction

  assign align_d = ex_q - ey_q;

  fp_align_shifter #(
    .W_IN (XW),
    .SH_W (EXP_W)
  ) u_align (
    .mant_i  (my_q),
    .shamt_i (align_d),
    .mant_o  (my_shift)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    sx_d      = sx_q;
    eff_sub_d = eff_sub_q;
    ex_d      = ex_q;
    ey_d      = ey_q;
    mx_d      = mx_q;
    my_d      = my_q;
    sum_d     = sum_q;
    exp_d     = exp_q;
    res_d     = res_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    inv_d     = inv_q;

    // Denormal inputs are flushed: exponent 0 forces a zero mantissa.
    ea      = a_q[W-2:MAN_W];
    eb      = b_q[W-2:MAN_W];
    ma      = (ea == '0) ? '0 : a_q[MAN_W-1:0];
    mb      = (eb == '0) ? '0 : b_q[MAN_W-1:0];
    sb_eff  = b_q[W-1] ^ op_q;
    swap    = {eb, mb} > {ea, ma};
    sum_add = eff_sub_q ? ({1'b0, mx_q} - {1'b0, my_q}) : ({1'b0, mx_q} + {1'b0, my_q});
    rnd     = round_man(sum_q[MAN_W+3:0]);
    exp_rnd = rnd[MAN_W+1] ? exp_q + (EXP_W+1)'(1) : exp_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          inv_d   = 1'b0;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        if (ea == EXP_ONES || eb == EXP_ONES) begin
          res_d   = QNAN;
          inv_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          eff_sub_d = a_q[W-1] ^ sb_eff;
          if (swap) begin
            sx_d = sb_eff;
            ex_d = eb;
            ey_d = ea;
            mx_d = {(eb != '0), mb, 3'b000};
            my_d = {(ea != '0), ma, 3'b000};
          end else begin
            sx_d = a_q[W-1];
            ex_d = ea;
            ey_d = eb;
            mx_d = {(ea != '0), ma, 3'b000};
            my_d = {(eb != '0), mb, 3'b000};
          end
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        my_d    = my_shift;
        state_d = S_ADD;
      end
      S_ADD: begin
        sum_d = sum_add;
        exp_d = {1'b0, ex_q};
        if (sum_add == '0) begin
          res_d   = '0;
          state_d = S_DONE;
        end else begin
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (sum_q[SW-1]) begin
          sum_d = {1'b0, sum_q[SW-1:2], sum_q[1] | sum_q[0]};
          exp_d = exp_q + (EXP_W+1)'(1);
        end else if (!sum_q[SW-2]) begin
          if (exp_q == (EXP_W+1)'(1)) begin
            res_d   = {sx_q, {(W-1){1'b0}}};
            unf_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            sum_d = {sum_q[SW-2:0], 1'b0};
            exp_d = exp_q - (EXP_W+1)'(1);
          end
        end else begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        if (exp_rnd >= {1'b0, EXP_ONES}) begin
          res_d = {sx_q, EXP_ONES, {MAN_W{1'b0}}};
          ovf_d = 1'b1;
        end else begin
          res_d = {sx_q, exp_rnd[EXP_W-1:0], rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0]};
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      inv_q   <= inv_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q       <= a_d;
    b_q       <= b_d;
    op_q      <= op_d;
    sx_q      <= sx_d;
    eff_sub_q <= eff_sub_d;
    ex_q      <= ex_d;
    ey_q      <= ey_d;
    mx_q      <= mx_d;
    my_q      <= my_d;
    sum_q     <= sum_d;
    exp_q     <= exp_d;
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign res       = res_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;
  assign inv       = inv_q;

endmodule

// File: tb/tb_fp_addsub_unit.sv
// Directed bench for fp_addsub_unit (single precision) with an expected-result queue.
module tb_fp_addsub_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        op = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_ready, out_valid, ovf, unf, inv;
  logic [31:0] res;

  always #5 clk = ~clk;

  fp_addsub_unit #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .ovf       (ovf),
    .unf       (unf),
    .inv       (inv)
  );

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flags;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

`ifdef FPADD_ROUND_NEAREST_EN
  localparam logic [31:0] ROUND_EXP = 32'h3F800001;
`else
  localparam logic [31:0] ROUND_EXP = 32'h3F800000;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                       input logic top, input logic [31:0] eres, input logic [2:0] eflg,
                       input int elat, input int hold);
    exp_t e;
    int   n;
    sb.push_back('{eres, eflg, elat});
    @(negedge clk);
    check({tag, ":in_ready_idle"}, 64'(in_ready), 64'(1));
    a = ta; b = tb_v; op = top; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, ":out_valid"}, 64'(out_valid), 64'(1));
    e = sb.pop_front();
    check({tag, ":res"}, 64'(res), 64'(e.res));
    check({tag, ":flags"}, 64'({ovf, unf, inv}), 64'(e.flags));
    check({tag, ":latency"}, 64'(n), 64'(e.lat));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ":hold_res"}, 64'(res), 64'(e.res));
      check({tag, ":hold_in_ready"}, 64'(in_ready), 64'(0));
      check({tag, ":hold_out_valid"}, 64'(out_valid), 64'(1));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ":back_idle"}, 64'(in_ready), 64'(1));
    check({tag, ":out_dropped"}, 64'(out_valid), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("rst:in_ready", 64'(in_ready), 64'(1));
    check("rst:out_valid", 64'(out_valid), 64'(0));
    check("rst:res", 64'(res), 64'(0));
    check("rst:flags", 64'({ovf, unf, inv}), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    do_op("add_1p1",   32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 6, 0);
    do_op("sub_exact", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000, 3, 0);
    do_op("sub_cancel",32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 3'b000, 29, 0);
    do_op("ovf",       32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b100, 6, 0);
    do_op("nan_in",    32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b001, 1, 0);
    do_op("inf_in",    32'h7F800000, 32'h3F800000, 1'b1, 32'h7FC00000, 3'b001, 1, 0);
    do_op("round",     32'h3F800000, 32'h33C00000, 1'b0, ROUND_EXP,    3'b000, 5, 0);
    do_op("zero_a",    32'h00000000, 32'h40400000, 1'b0, 32'h40400000, 3'b000, 5, 0);
    do_op("denorm_a",  32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000, 5, 0);
    do_op("neg_res",   32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000, 6, 0);
    do_op("neg_a",     32'hBF800000, 32'h40400000, 1'b0, 32'h40000000, 3'b000, 5, 0);
    do_op("unf",       32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 3'b010, 4, 0);
    do_op("hold",      32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 6, 3);

    // Abandon a long normalisation with an asynchronous reset.
    @(negedge clk);
    a = 32'h3F800000; b = 32'h3F7FFFFF; op = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("midnorm:busy", 64'(in_ready), 64'(0));
    rst = 1'b1;
    #1;
    check("midnorm:in_ready", 64'(in_ready), 64'(1));
    check("midnorm:out_valid", 64'(out_valid), 64'(0));
    check("midnorm:res", 64'(res), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("midnorm:no_result", 64'(out_valid), 64'(0));

    do_op("after_rst", 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000, 5, 0);

    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
